fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 10 +
 rtl/fifo_rd_stream_if.sv | 19 +
 rtl/fifo_rd_stream.sv | 91 +++++++++
 tb/tb_fifo_rd_stream.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side drain stage: occupancy states and buffer depth.
package fifo_rd_stream_pkg;
  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_state_t;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus outgoing valid/ready stream; master side is the drain stage.
interface fifo_rd_stream_if #(parameter int DATA_WIDTH = 8);
  logic                  fifo_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_r_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_r_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pulls words from the async FIFO into a 2-entry skid buffer
// and streams them out. Optional delivered-word counter under FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 r_clk,
  input  logic                 rrst_n,
  fifo_rd_stream_if.master     io
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] word_cnt
`endif
);

  if (CNT_WIDTH < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $error("fifo_rd_stream: widths must be >= 1");
  end

  occ_state_t                            state_q, state_d;
  logic                                  inflight_q;
  logic                                  head_q, tail_q;
  logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0]  buf_q;
  logic                                  push, pop;
  logic [1:0]                            occ_cnt;
  logic [2:0]                            level;

  assign occ_cnt = state_q;
  assign pop     = io.m_valid & io.m_ready;
  assign push    = inflight_q;

  // Entries committed after this cycle, counting the word already in flight;
  // pop is folded in so a draining buffer keeps reading every cycle.
  assign level        = {1'b0, occ_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  assign io.fifo_r_en = rrst_n & ~io.fifo_empty & (level < 3'd2);

  assign io.m_valid = (state_q != S_EMPTY);
  assign io.m_data  = buf_q[head_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (push && !pop) state_d = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_d = S_TWO;
        else if (pop && !push) state_d = S_EMPTY;
      end
      S_TWO:   if (pop && !push) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) state_q <= S_EMPTY;
    else         state_q <= state_d;
  end

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n) begin
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q      <= '0;
    end else begin
      inflight_q <= io.fifo_r_en;
      if (push) begin
        buf_q[tail_q] <= io.fifo_rdata;
        tail_q        <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q;

  always_ff @(posedge r_clk or negedge rrst_n) begin
    if (!rrst_n)  word_cnt_q <= '0;
    else if (pop) word_cnt_q <= word_cnt_q + 1'b1;
  end

  assign word_cnt = word_cnt_q;
`endif

  a_no_overflow: assert property (@(posedge r_clk) disable iff (!rrst_n)
    !(push && !pop && state_q == S_TWO))
    else $error("fifo_rd_stream: push into full buffer");

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a queue-backed FIFO model and stream monitor.
module tb_fifo_rd_stream;
  logic       r_clk;
  logic       rrst_n = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rdata = 8'h00;
  logic       m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] word_cnt;
`endif

  int tests  = 0;
  int errors = 0;
  int rd_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] got[$];

  fifo_rd_stream_if #(.DATA_WIDTH(8)) io ();
  assign io.fifo_empty = fifo_empty;
  assign io.fifo_rdata = fifo_rdata;
  assign io.m_ready    = m_ready;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .r_clk  (r_clk),
    .rrst_n (rrst_n),
    .io     (io)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // FIFO model: registered empty flag, data one cycle after the strobe.
  always @(posedge r_clk) begin
    if (io.fifo_r_en) begin
      rd_cnt++;
      if (q.size() > 0) fifo_rdata <= q.pop_front();
    end
    fifo_empty <= (q.size() == 0);
    if (io.m_valid && m_ready) got.push_back(io.m_data);
  end

  task automatic test_reset();
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    q.push_back(8'hEE);
    repeat (2) @(negedge r_clk);
    tests++; if (io.fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en got %b exp 0", io.fifo_r_en); end
    tests++; if (io.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", io.m_valid); end
    tests++; if (io.m_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", io.m_data); end
`ifdef FIFO_RD_STREAM_STATS_EN
    tests++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", word_cnt); end
`endif
    q.delete();
    repeat (2) @(negedge r_clk);
    rrst_n = 1'b1;
    @(negedge r_clk);
  endtask

  task automatic test_single();
    int r0, g0;
    m_ready = 1'b1;
    r0 = rd_cnt; g0 = got.size();
    q.push_back(8'hA5);
    @(negedge r_clk);
    tests++; if (io.fifo_r_en !== 1'b1) begin errors++; $display("FAIL single_r_en got %b exp 1", io.fifo_r_en); end
    @(negedge r_clk);
    tests++; if (io.fifo_r_en !== 1'b0 || io.m_valid !== 1'b0) begin
      errors++; $display("FAIL single_c1 r_en %b valid %b exp 0 0", io.fifo_r_en, io.m_valid); end
    @(negedge r_clk);
    tests++; if (io.m_valid !== 1'b1 || io.m_data !== 8'hA5) begin
      errors++; $display("FAIL single_out valid %b data %h exp 1 a5", io.m_valid, io.m_data); end
    @(negedge r_clk);
    tests++; if (io.m_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", io.m_valid); end
    tests++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL single_reads got %0d exp 1", rd_cnt - r0); end
    tests++; if (got.size() - g0 !== 1) begin errors++; $display("FAIL single_words got %0d exp 1", got.size() - g0); end
  endtask

  task automatic test_stream();
    int n;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] c0;
    c0 = word_cnt;
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    n = 0;
    while (io.m_valid !== 1'b1 && n < 20) begin @(negedge r_clk); n++; end
    tests++; if (n >= 20) begin errors++; $display("FAIL stream_timeout got no valid exp valid"); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (io.m_valid !== 1'b1 || io.m_data !== 8'(i)) begin
        errors++; $display("FAIL stream_word%0d valid %b data %h exp 1 %h", i, io.m_valid, io.m_data, 8'(i));
      end
      @(negedge r_clk);
    end
    tests++; if (io.m_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b exp 0", io.m_valid); end
`ifdef FIFO_RD_STREAM_STATS_EN
    tests++; if (16'(word_cnt - c0) !== 16'd16) begin
      errors++; $display("FAIL stream_cnt got %0d exp 16", 16'(word_cnt - c0)); end
`endif
  endtask

  task automatic test_back_pressure();
    int r0, g0, n;
    logic held;
    m_ready = 1'b0;
    r0 = rd_cnt; g0 = got.size();
    held = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(8'h10 + 8'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge r_clk);
      if (c >= 3 && (io.m_valid !== 1'b1 || io.m_data !== 8'h10)) held = 1'b0;
    end
    tests++; if (rd_cnt - r0 !== 2) begin errors++; $display("FAIL bp_reads got %0d exp 2", rd_cnt - r0); end
    tests++; if (!held) begin errors++; $display("FAIL bp_hold got unstable exp steady 10"); end
    tests++; if (io.m_data !== 8'h10) begin errors++; $display("FAIL bp_data got %h exp 10", io.m_data); end
    m_ready = 1'b1;
    n = 0;
    while (got.size() - g0 < 4 && n < 40) begin @(negedge r_clk); n++; end
    repeat (3) @(negedge r_clk);
    tests++; if (got.size() - g0 !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got.size() - g0); end
    for (int i = 0; i < 4 && g0 + i < got.size(); i++) begin
      tests++;
      if (got[g0+i] !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL bp_word%0d got %h exp %h", i, got[g0+i], 8'h10 + 8'(i)); end
    end
  endtask

  task automatic test_toggle_ready();
    int g0, n;
    int bad;
    g0 = got.size();
    for (int i = 0; i < 32; i++) q.push_back(8'h20 + 8'(i));
    n = 0;
    while (got.size() - g0 < 32 && n < 300) begin
      @(negedge r_clk);
      m_ready = ~m_ready;
      n++;
    end
    m_ready = 1'b1;
    repeat (4) @(negedge r_clk);
    tests++; if (got.size() - g0 !== 32) begin errors++; $display("FAIL toggle_count got %0d exp 32", got.size() - g0); end
    bad = 0;
    for (int i = 0; i < 32 && g0 + i < got.size(); i++)
      if (got[g0+i] !== 8'h20 + 8'(i)) bad++;
    tests++; if (bad != 0) begin errors++; $display("FAIL toggle_order got %0d bad words exp 0", bad); end
  endtask

  task automatic test_mid_reset();
    int g0, g1, n;
    m_ready = 1'b1;
    g0 = got.size();
    for (int i = 0; i < 8; i++) q.push_back(8'h40 + 8'(i));
    n = 0;
    while (got.size() - g0 < 3 && n < 40) begin @(negedge r_clk); n++; end
    tests++; if (n >= 40) begin errors++; $display("FAIL mid_timeout got %0d words exp 3", got.size() - g0); end
    rrst_n = 1'b0;
    #1;
    tests++; if (io.m_valid !== 1'b0 || io.fifo_r_en !== 1'b0) begin
      errors++; $display("FAIL mid_rst valid %b r_en %b exp 0 0", io.m_valid, io.fifo_r_en); end
`ifdef FIFO_RD_STREAM_STATS_EN
    tests++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", word_cnt); end
`endif
    q.delete();
    repeat (2) @(negedge r_clk);
    rrst_n = 1'b1;
    @(negedge r_clk);
    g1 = got.size();
    for (int i = 0; i < 3; i++) q.push_back(8'h50 + 8'(i));
    n = 0;
    while (got.size() - g1 < 3 && n < 40) begin @(negedge r_clk); n++; end
    repeat (4) @(negedge r_clk);
    tests++; if (got.size() - g1 !== 3) begin errors++; $display("FAIL mid_count got %0d exp 3", got.size() - g1); end
    for (int i = 0; i < 3 && g1 + i < got.size(); i++) begin
      tests++;
      if (got[g1+i] !== 8'h50 + 8'(i)) begin
        errors++; $display("FAIL mid_word%0d got %h exp %h", i, got[g1+i], 8'h50 + 8'(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_back_pressure();
    test_toggle_ready();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
